// File: rtl/vga_timing_pkg.sv
// 800x600@60 raster constants, counter widths and the colour-bar lookup used by vga_timing_gen.
package vga_timing_pkg;

   localparam int H_ACTIVE = 800;
   localparam int H_FP     = 40;
   localparam int H_SYNC   = 128;
   localparam int H_BP     = 88;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

   localparam int V_ACTIVE = 600;
   localparam int V_FP     = 1;
   localparam int V_SYNC   = 4;
   localparam int V_BP     = 23;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam int HCW = 11;
   localparam int VCW = 10;

   localparam int H_SYNC_START = H_ACTIVE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int V_SYNC_START = V_ACTIVE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   localparam int BAR_WIDTH = 100;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb_t;

   function automatic rgb_t bar_colour(input logic [2:0] k);
      case (k)
         3'd0:    return '{r: 4'hF, g: 4'hF, b: 4'hF};
         3'd1:    return '{r: 4'hF, g: 4'hF, b: 4'h0};
         3'd2:    return '{r: 4'h0, g: 4'hF, b: 4'hF};
         3'd3:    return '{r: 4'h0, g: 4'hF, b: 4'h0};
         3'd4:    return '{r: 4'hF, g: 4'h0, b: 4'hF};
         3'd5:    return '{r: 4'hF, g: 4'h0, b: 4'h0};
         3'd6:    return '{r: 4'h0, g: 4'h0, b: 4'hF};
         default: return '{r: 4'h0, g: 4'h0, b: 4'h0};
      endcase
   endfunction

endpackage

// File: rtl/vga_timing_gen_pclk_phase_acc.sv
// Fractional clock-enable divider: tick rate = clk * NUM / DEN, ticks evenly interleaved.
module pclk_phase_acc #(
   parameter int NUM = 2,
   parameter int DEN = 5
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int AW = $clog2(DEN) + 1;

   if (NUM * 2 > DEN) begin : g_ratio_check
      $error("pclk_phase_acc: NUM*2 must not exceed DEN");
   end

   logic [AW-1:0] acc;
   logic [AW:0]   sum;

   assign sum  = {1'b0, acc} + (AW+1)'(NUM);
   // tick is combinational from the registered phase; the caller registers it with its counters
   assign tick = (sum >= (AW+1)'(DEN));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       acc <= '0;
      else if (tick) acc <= AW'(sum - (AW+1)'(DEN));
      else           acc <= AW'(sum);
   end

endmodule

// File: rtl/vga_timing_gen.sv
// 800x600@60 raster timing generator with a fractional pixel enable from clk.
// Optional colour-bar test pattern when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter logic HS_POL   = 1'b1,
   parameter logic VS_POL   = 1'b1,
   parameter int   PCLK_NUM = 2,
   parameter int   PCLK_DEN = 5
) (
   input  logic           clk,
   input  logic           rst,
   output logic           pclk_en,
   output logic           pclk_mirror,
   output logic [HCW-1:0] hcount,
   output logic [VCW-1:0] vcount,
   output logic           hs,
   output logic           vs,
   output logic           de,
   output logic           frame_start,
   output logic [3:0]     r,
   output logic [3:0]     g,
   output logic [3:0]     b
);

   logic           tick;
   logic [HCW-1:0] h_nxt;
   logic [VCW-1:0] v_nxt;
   logic           hs_nxt, vs_nxt, de_nxt;

   pclk_phase_acc #(.NUM(PCLK_NUM), .DEN(PCLK_DEN)) u_phase_acc (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   always_comb begin
      h_nxt = hcount + HCW'(1);
      v_nxt = vcount;
      if (hcount == HCW'(H_TOTAL - 1)) begin
         h_nxt = '0;
         v_nxt = (vcount == VCW'(V_TOTAL - 1)) ? '0 : vcount + VCW'(1);
      end
   end

   // sync/de decode from the next counter values so they line up with the counters
   always_comb begin
      hs_nxt = (h_nxt >= HCW'(H_SYNC_START) && h_nxt < HCW'(H_SYNC_END)) ? HS_POL : ~HS_POL;
      vs_nxt = (v_nxt >= VCW'(V_SYNC_START) && v_nxt < VCW'(V_SYNC_END)) ? VS_POL : ~VS_POL;
      de_nxt = (h_nxt < HCW'(H_ACTIVE)) && (v_nxt < VCW'(V_ACTIVE));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pclk_en     <= 1'b0;
         pclk_mirror <= 1'b0;
         frame_start <= 1'b0;
         hcount      <= '0;
         vcount      <= '0;
         hs          <= ~HS_POL;
         vs          <= ~VS_POL;
         de          <= 1'b0;
      end else begin
         pclk_en     <= tick;
         pclk_mirror <= pclk_en;
         frame_start <= tick && (h_nxt == '0) && (v_nxt == '0);
         if (tick) begin
            hcount <= h_nxt;
            vcount <= v_nxt;
            hs     <= hs_nxt;
            vs     <= vs_nxt;
            de     <= de_nxt;
         end
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   rgb_t rgb_q, rgb_nxt;

   always_comb begin
      rgb_nxt = '0;
      if (de_nxt) rgb_nxt = bar_colour(3'(h_nxt / HCW'(BAR_WIDTH)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       rgb_q <= '0;
      else if (tick) rgb_q <= rgb_nxt;
   end

   assign r = rgb_q.r;
   assign g = rgb_q.g;
   assign b = rgb_q.b;
`else
   assign r = 4'h0;
   assign g = 4'h0;
   assign b = 4'h0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: raster position model driven by pixel index, random and boundary jumps.
module tb_vga_timing_gen;

   localparam int HT = 1056;
   localparam int VT = 628;
   localparam int FRAME = HT * VT;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pclk_en, pclk_mirror, hs, vs, de, frame_start;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic [3:0]  r, g, b;

   int errors = 0;
   int checks = 0;

   // model state: n = clk edges since reset release, pos = pixel index currently shown
   int n, pos;
   bit stale, e_tick, e_tick_d;

   vga_timing_gen dut (
      .clk(clk), .rst(rst), .pclk_en(pclk_en), .pclk_mirror(pclk_mirror),
      .hcount(hcount), .vcount(vcount), .hs(hs), .vs(vs), .de(de),
      .frame_start(frame_start), .r(r), .g(g), .b(b)
   );

   always #5 clk = ~clk;

   function automatic int e_h(); return pos % HT; endfunction
   function automatic int e_v(); return pos / HT; endfunction
   function automatic bit e_hs(); return (e_h() >= 840) && (e_h() <= 967); endfunction
   function automatic bit e_vs(); return (e_v() >= 601) && (e_v() <= 604); endfunction
   function automatic bit e_de(); return (e_h() < 800) && (e_v() < 600); endfunction

   function automatic logic [11:0] e_rgb();
`ifdef VGA_TEST_PATTERN_EN
      if (!e_de()) return 12'h000;
      case (e_h() / 100)
         0: return 12'hFFF;
         1: return 12'hFF0;
         2: return 12'h0FF;
         3: return 12'h0F0;
         4: return 12'hF0F;
         5: return 12'hF00;
         6: return 12'h00F;
         default: return 12'h000;
      endcase
`else
      return 12'h000;
`endif
   endfunction

   // pixel tick on edge n when floor(n*2/5) steps up
   task automatic advance();
      @(posedge clk);
      #1;
      n++;
      e_tick_d = e_tick;
      e_tick   = ((n * 2) / 5) != (((n - 1) * 2) / 5);
      if (e_tick) begin
         pos   = (pos + 1) % FRAME;
         stale = 1'b0;
      end
   endtask

   task automatic release_rst();
      @(negedge clk);
      rst = 1'b0;
      n = 0; pos = 0; stale = 1'b1; e_tick = 1'b0; e_tick_d = 1'b0;
   endtask

   task automatic jump(input int h, input int v);
      @(negedge clk);
      force dut.hcount = 11'(h);
      force dut.vcount = 10'(v);
      #1;
      release dut.hcount;
      release dut.vcount;
      pos = v * HT + h;
      stale = 1'b1;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({pclk_en, pclk_mirror, de, frame_start, hs, vs} !== 6'b000000 ||
          hcount !== 11'd0 || vcount !== 10'd0 || {r, g, b} !== 12'h000) begin
         errors++;
         $display("FAIL reset: en=%b mir=%b de=%b fs=%b hs=%b vs=%b h=%0d v=%0d rgb=%h, required all zero",
                  pclk_en, pclk_mirror, de, frame_start, hs, vs, hcount, vcount, {r, g, b});
      end
   endtask

   task automatic test_cadence();
      int pulses = 0, last_n = 0, prev_gap = 0, gap;
      release_rst();
      repeat (50) begin
         advance();
         checks++;
         if (pclk_en !== e_tick) begin
            errors++;
            $display("FAIL cadence_en n=%0d: got %b required %b", n, pclk_en, e_tick);
         end
         checks++;
         if (pclk_mirror !== e_tick_d) begin
            errors++;
            $display("FAIL cadence_mirror n=%0d: got %b required %b", n, pclk_mirror, e_tick_d);
         end
         if (pclk_en === 1'b1) begin
            pulses++;
            gap = n - last_n;
            checks++;
            if (gap != 2 && gap != 3 || (prev_gap != 0 && gap == prev_gap) ||
                (prev_gap == 0 && gap != 3)) begin
               errors++;
               $display("FAIL cadence_gap n=%0d: got %0d prev %0d required alternating 3,2", n, gap, prev_gap);
            end
            prev_gap = gap;
            last_n = n;
         end
      end
      checks++;
      if (pulses != 20) begin
         errors++;
         $display("FAIL cadence_count: got %0d pulses required 20", pulses);
      end
   endtask

   task automatic test_raster();
      int sc_h[$] = '{830, 790, 1040, 1050, 1050, 1045, 960};
      int sc_v[$] = '{5,   599, 599,  600,  603,  627,  300};
      int sc_t[$] = '{160, 30,  40,   20,   20,   40,   20};
      int left, budget, last_h;
      bit mir_valid;
      repeat (4) begin
         sc_h.push_back($urandom_range(0, HT - 1));
         sc_v.push_back($urandom_range(0, VT - 1));
         sc_t.push_back($urandom_range(50, 150));
      end
      foreach (sc_h[i]) begin
         jump(sc_h[i], sc_v[i]);
         left = sc_t[i];
         budget = left * 3 + 10;
         mir_valid = 1'b0;
         while (left > 0 && budget > 0) begin
            advance();
            budget--;
            if (e_tick) left--;
            checks++;
            if (pclk_en !== e_tick || pclk_mirror !== e_tick_d) begin
               errors++;
               $display("FAIL raster_en n=%0d: en=%b mir=%b required %b %b", n, pclk_en, pclk_mirror, e_tick, e_tick_d);
            end
            checks++;
            if (hcount !== 11'(e_h()) || vcount !== 10'(e_v())) begin
               errors++;
               $display("FAIL raster_count: got (%0d,%0d) required (%0d,%0d)", hcount, vcount, e_h(), e_v());
            end
            checks++;
            if (frame_start !== (e_tick && pos == 0)) begin
               errors++;
               $display("FAIL raster_frame_start at (%0d,%0d): got %b", e_h(), e_v(), frame_start);
            end
            if (!stale) begin
               checks++;
               if (hs !== e_hs() || vs !== e_vs() || de !== e_de()) begin
                  errors++;
                  $display("FAIL raster_sync at (%0d,%0d): hs/vs/de got %b%b%b required %b%b%b",
                           e_h(), e_v(), hs, vs, de, e_hs(), e_vs(), e_de());
               end
               checks++;
               if ({r, g, b} !== e_rgb()) begin
                  errors++;
                  $display("FAIL raster_rgb at (%0d,%0d): got %h required %h", e_h(), e_v(), {r, g, b}, e_rgb());
               end
            end
            if (pclk_mirror === 1'b1) begin
               if (mir_valid) begin
                  checks++;
                  if (hcount !== 11'((last_h + 1) % HT)) begin
                     errors++;
                     $display("FAIL mirror_step: got %0d required %0d", hcount, (last_h + 1) % HT);
                  end
               end
               last_h = int'(hcount);
               mir_valid = 1'b1;
            end
         end
         checks++;
         if (left > 0) begin
            errors++;
            $display("FAIL raster_timeout: %0d ticks missing", left);
         end
      end
   endtask

   task automatic test_line();
      int ticks = 0, hs_rise = 0, hs_width = 0, de_cnt = 0, rise_h = -1, budget = 4000;
      bit hs_d;
      jump(1055, 20);
      advance();
      while (!e_tick && budget > 0) begin advance(); budget--; end
      hs_d = hs;
      while (ticks < HT - 1 && budget > 0) begin
         advance();
         budget--;
         if (e_tick) begin
            ticks++;
            if (hs && !hs_d) begin hs_rise++; rise_h = int'(hcount); end
            if (hs) hs_width++;
            if (de) de_cnt++;
            hs_d = hs;
         end
      end
      checks++;
      if (hs_rise != 1 || rise_h != 840 || hs_width != 128) begin
         errors++;
         $display("FAIL line_hs: rises=%0d at h=%0d width=%0d required 1 at 840 width 128", hs_rise, rise_h, hs_width);
      end
      checks++;
      if (de_cnt != 799) begin
         errors++;
         $display("FAIL line_de: got %0d de ticks after h=0 required 799", de_cnt);
      end
   endtask

   task automatic test_pattern();
      int budget;
      int hs_q[$] = '{249, 899, 49, 649};
      logic [11:0] req[$];
`ifdef VGA_TEST_PATTERN_EN
      req = '{12'h0FF, 12'h000, 12'hFFF, 12'h00F};
`else
      req = '{12'h000, 12'h000, 12'h000, 12'h000};
`endif
      foreach (hs_q[i]) begin
         jump(hs_q[i], 10);
         budget = 6;
         advance();
         while (!e_tick && budget > 0) begin advance(); budget--; end
         checks++;
         if ({r, g, b} !== req[i] || hcount !== 11'(hs_q[i] + 1)) begin
            errors++;
            $display("FAIL pattern h=%0d: got rgb %h at h=%0d required %h", hs_q[i] + 1, {r, g, b}, hcount, req[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int budget = 8;
      jump(500, 300);
      repeat (4) advance();
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checks++;
      if ({pclk_en, pclk_mirror, de, frame_start, hs, vs} !== 6'b000000 ||
          hcount !== 11'd0 || vcount !== 10'd0 || {r, g, b} !== 12'h000) begin
         errors++;
         $display("FAIL reset_mid: en=%b mir=%b de=%b hs=%b vs=%b h=%0d v=%0d rgb=%h, required reset values",
                  pclk_en, pclk_mirror, de, hs, vs, hcount, vcount, {r, g, b});
      end
      repeat (3) @(posedge clk);
      release_rst();
      advance();
      while (!e_tick && budget > 0) begin advance(); budget--; end
      checks++;
      if (pclk_en !== 1'b1 || hcount !== 11'd1 || vcount !== 10'd0 || n != 3) begin
         errors++;
         $display("FAIL reset_restart: en=%b h=%0d v=%0d n=%0d required 1,1,0,3", pclk_en, hcount, vcount, n);
      end
   endtask

   initial begin
      test_reset();
      test_cadence();
      test_raster();
      test_line();
      test_pattern();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
